rvfi_commit_packer: RTL

//  Producer side of the RVFI retirement stream. Builds one rvfi_pkg::rvfi_instr_t per commit port

---
 rtl/rvfi_pkg.sv | 47 ++++
 rtl/rvfi_mem_scoreboard.sv | 59 +++++
 rtl/rvfi_commit_packer.sv | 113 +++++++++++
 3 files changed

// File: rtl/rvfi_pkg.sv
// RVFI record types shared by the commit packer and downstream trace/formal consumers.
// Includes the LSU side-record held until retirement and the FP-destination decode helper.
package rvfi_pkg;

  localparam int XLEN = 64;
  localparam int VLEN = 39;

  typedef struct packed {
    logic              valid;
    logic [63:0]       order;
    logic [31:0]       insn;
    logic              trap;
    logic [XLEN-1:0]   cause;
    logic [1:0]        mode;
    logic [4:0]        rd_addr;
    logic [XLEN-1:0]   rd_wdata;
    logic [XLEN-1:0]   pc_rdata;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_rmask;
    logic [XLEN/8-1:0] mem_wmask;
    logic [XLEN-1:0]   mem_wdata;
  } rvfi_instr_t;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] wmask;
    logic [XLEN/8-1:0] rmask;
  } rvfi_mem_rec_t;

  // True when the instruction writes an FP register, so rd=0 names f0 rather than x0.
  function automatic logic is_fp_dest(input logic [31:0] insn);
    logic r_fp;
    r_fp = 1'b0;
    if (insn[1:0] != 2'b11) begin
      r_fp = (insn[0] == 1'b0) && (insn[15:13] == 3'b001);
    end else begin
      case (insn[6:0])
        7'b0000111, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: r_fp = 1'b1;
        7'b1010011: r_fp = !(insn[31:27] inside {5'b10100, 5'b11000, 5'b11100});
        default:    r_fp = 1'b0;
      endcase
    end
    return r_fp;
  endfunction

endpackage

// File: rtl/rvfi_mem_scoreboard.sv
// Per-trans_id holding store for LSU access info; multi-port read-and-clear with same-cycle bypass.
// Flush invalidates every entry and discards the LSU write of that cycle.
module rvfi_mem_scoreboard
  import rvfi_pkg::*;
#(
  parameter int NR_PORTS   = 2,
  parameter int NR_ENTRIES = 8,
  parameter int ID_BITS    = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_flush,
  input  logic                          i_wr_vld,
  input  logic [ID_BITS-1:0]            i_wr_id,
  input  rvfi_mem_rec_t                 i_wr_rec,
  input  logic [NR_PORTS-1:0]           i_rd_en,
  input  logic [NR_PORTS*ID_BITS-1:0]   i_rd_id,
  output rvfi_mem_rec_t [NR_PORTS-1:0]  o_rd_rec
);

  logic [NR_ENTRIES-1:0] r_vld;
  rvfi_mem_rec_t         r_mem [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] w_clr;
  logic                  w_bypass;

  always_comb begin
    w_clr    = '0;
    w_bypass = 1'b0;
    for (int p = 0; p < NR_PORTS; p++) begin
      o_rd_rec[p] = '0;
      if (i_rd_en[p]) begin
        w_clr[i_rd_id[p*ID_BITS +: ID_BITS]] = 1'b1;
        if (i_wr_vld && (i_wr_id == i_rd_id[p*ID_BITS +: ID_BITS])) begin
          o_rd_rec[p] = i_wr_rec;
          w_bypass    = 1'b1;
        end else if (r_vld[i_rd_id[p*ID_BITS +: ID_BITS]]) begin
          o_rd_rec[p] = r_mem[i_rd_id[p*ID_BITS +: ID_BITS]];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
    end else if (i_flush) begin
      r_vld <= '0;
    end else begin
      r_vld <= r_vld & ~w_clr;
      if (i_wr_vld && !w_bypass) r_vld[i_wr_id] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through r_vld.
  always_ff @(posedge i_clk) begin
    if (i_wr_vld && !w_bypass && !i_flush) r_mem[i_wr_id] <= i_wr_rec;
  end

endmodule

// File: rtl/rvfi_commit_packer.sv
// Builds one registered RVFI record per commit port (1 cycle latency), merging held LSU info.
// No backpressure: every commit sampled in cycle N is presented in cycle N+1 for one cycle.
module rvfi_commit_packer
  import rvfi_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int NR_SB_ENTRIES   = 8,
  localparam int TRANS_ID_BITS  = $clog2(NR_SB_ENTRIES)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     flush_i,
  input  logic                                     lsu_valid_i,
  input  logic [TRANS_ID_BITS-1:0]                 lsu_trans_id_i,
  input  logic [XLEN-1:0]                          lsu_addr_i,
  input  logic [XLEN-1:0]                          lsu_wdata_i,
  input  logic [XLEN/8-1:0]                        lsu_wmask_i,
  input  logic [XLEN/8-1:0]                        lsu_rmask_i,
  input  logic [NR_COMMIT_PORTS-1:0]               commit_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0]               commit_ex_i,
  input  logic [NR_COMMIT_PORTS*XLEN-1:0]          commit_cause_i,
  input  logic [NR_COMMIT_PORTS*TRANS_ID_BITS-1:0] commit_trans_id_i,
  input  logic [NR_COMMIT_PORTS*VLEN-1:0]          commit_pc_i,
  input  logic [NR_COMMIT_PORTS*32-1:0]            commit_insn_i,
  input  logic [NR_COMMIT_PORTS*5-1:0]             commit_rd_i,
  input  logic [NR_COMMIT_PORTS*XLEN-1:0]          commit_rd_wdata_i,
  input  logic [1:0]                               priv_lvl_i,
  output rvfi_instr_t [NR_COMMIT_PORTS-1:0]        rvfi_o
);

  logic [NR_COMMIT_PORTS-1:0]           w_lookup;
  rvfi_mem_rec_t                        w_lsu_rec;
  rvfi_mem_rec_t [NR_COMMIT_PORTS-1:0]  w_mem;
  rvfi_instr_t [NR_COMMIT_PORTS-1:0]    w_rec;
  rvfi_instr_t [NR_COMMIT_PORTS-1:0]    r_rvfi;
  logic [63:0]                          r_order;
  logic [63:0]                          w_retired;
  logic                                 w_dup_id;

  assign w_lookup  = commit_valid_i | commit_ex_i;
  assign w_lsu_rec = '{addr: lsu_addr_i, wdata: lsu_wdata_i, wmask: lsu_wmask_i, rmask: lsu_rmask_i};

  rvfi_mem_scoreboard #(
    .NR_PORTS  (NR_COMMIT_PORTS),
    .NR_ENTRIES(NR_SB_ENTRIES),
    .ID_BITS   (TRANS_ID_BITS)
  ) u_sb (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_flush (flush_i),
    .i_wr_vld(lsu_valid_i),
    .i_wr_id (lsu_trans_id_i),
    .i_wr_rec(w_lsu_rec),
    .i_rd_en (w_lookup),
    .i_rd_id (commit_trans_id_i),
    .o_rd_rec(w_mem)
  );

  // Order is a prefix sum over older ports; trapping ports neither consume nor carry an order.
  always_comb begin
    w_retired = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      w_rec[p] = '0;
      if (w_lookup[p]) begin
        w_rec[p].insn     = commit_insn_i[p*32 +: 32];
        w_rec[p].pc_rdata = {{(XLEN-VLEN){commit_pc_i[p*VLEN+VLEN-1]}}, commit_pc_i[p*VLEN +: VLEN]};
        w_rec[p].mode     = priv_lvl_i;
      end
      if (commit_ex_i[p]) begin
        w_rec[p].trap  = 1'b1;
        w_rec[p].cause = commit_cause_i[p*XLEN +: XLEN];
      end else if (commit_valid_i[p]) begin
        w_rec[p].valid     = 1'b1;
        w_rec[p].order     = r_order + w_retired;
        w_rec[p].rd_addr   = commit_rd_i[p*5 +: 5];
        w_rec[p].rd_wdata  = (commit_rd_i[p*5 +: 5] == 5'd0 && !is_fp_dest(commit_insn_i[p*32 +: 32]))
                             ? '0 : commit_rd_wdata_i[p*XLEN +: XLEN];
        w_rec[p].mem_addr  = w_mem[p].addr;
        w_rec[p].mem_wdata = w_mem[p].wdata;
        w_rec[p].mem_wmask = w_mem[p].wmask;
        w_rec[p].mem_rmask = w_mem[p].rmask;
        w_retired          = w_retired + 64'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvfi  <= '0;
      r_order <= '0;
    end else begin
      r_rvfi  <= w_rec;
      r_order <= r_order + w_retired;
    end
  end

  assign rvfi_o = r_rvfi;

  always_comb begin
    w_dup_id = 1'b0;
    for (int a = 0; a < NR_COMMIT_PORTS; a++) begin
      for (int b = a + 1; b < NR_COMMIT_PORTS; b++) begin
        if (w_lookup[a] && w_lookup[b] &&
            commit_trans_id_i[a*TRANS_ID_BITS +: TRANS_ID_BITS] ==
            commit_trans_id_i[b*TRANS_ID_BITS +: TRANS_ID_BITS]) w_dup_id = 1'b1;
      end
    end
  end

  a_unique_trans_id: assert property (@(posedge clk_i) disable iff (rst_i) !w_dup_id)
    else $error("two commit ports share a trans_id");

endmodule
